gtech_serial_sub: RTL



---
 rtl/gtech_serial_sub.sv | 71 +++++++
 1 files changed

// File: rtl/gtech_serial_sub.sv
// gtech_serial_sub: bit-serial subtractor, one full-subtractor slice per clock, LSB first
module gtech_serial_sub #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] d,
    output logic             bout
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t           state;
    logic [WIDTH-1:0] ra, rb, res, res_next;
    logic [CW-1:0]    cnt;
    logic             br, dbit, br_next;

    always_comb begin
        dbit     = ra[0] ^ rb[0] ^ br;
        br_next  = (~ra[0] & rb[0]) | (~(ra[0] ^ rb[0]) & br);
        res_next = {dbit, res[WIDTH-1:1]};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            ra    <= '0;
            rb    <= '0;
            res   <= '0;
            cnt   <= '0;
            br    <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
            d     <= '0;
            bout  <= 1'b0;
        end else if (state == S_RUN) begin
            ra  <= ra >> 1;
            rb  <= rb >> 1;
            res <= res_next;
            br  <= br_next;
            cnt <= cnt + CW'(1);
            if (cnt == CW'(WIDTH - 1)) begin
                d     <= res_next;
                bout  <= br_next;
                busy  <= 1'b0;
                done  <= 1'b1;
                state <= S_DONE;
            end
        end else begin
            // IDLE and DONE accept a request identically, giving back-to-back operation
            done <= 1'b0;
            if (start) begin
                ra    <= a;
                rb    <= b;
                br    <= bin;
                cnt   <= '0;
                busy  <= 1'b1;
                state <= S_RUN;
            end else begin
                state <= S_IDLE;
            end
        end
    end
endmodule
